// File: rtl/alu_cond_writeback.sv
// alu_cond_writeback: single-entry execute/writeback register holding NZCV flags and gating writes on the condition code.
// Optional ALU_COND_SKIP_CNT_EN adds a saturating count of condition-failed beats on skip_cnt.
module alu_cond_writeback #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] alu_result,
    input  logic [3:0]   alu_flags,
    input  logic [3:0]   cond,
    input  logic         set_flags,
    input  logic         wr_req,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_result,
    output logic         out_wr_en,
    output logic [3:0]   flags_q,
    output logic         cond_pass
`ifdef ALU_COND_SKIP_CNT_EN
    ,
    output logic [7:0]   skip_cnt
`endif
);
    logic         out_valid_q, out_valid_d;
    logic [N-1:0] out_result_q, out_result_d;
    logic         out_wr_en_q, out_wr_en_d;
    logic [3:0]   flags_d;
    logic         accept;
    logic         base;
    assign in_ready   = !out_valid_q || out_ready;
    assign accept     = in_valid && in_ready;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_wr_en  = out_wr_en_q;
    // Odd condition codes are the complement of the preceding even code.
    always_comb begin
        base = 1'b1;
        case (cond[3:1])
            3'd0:    base = flags_q[2];
            3'd1:    base = flags_q[1];
            3'd2:    base = flags_q[3];
            3'd3:    base = flags_q[0];
            3'd4:    base = flags_q[1] && !flags_q[2];
            3'd5:    base = flags_q[3] == flags_q[0];
            3'd6:    base = !flags_q[2] && (flags_q[3] == flags_q[0]);
            default: base = 1'b1;
        endcase
        cond_pass = base ^ cond[0];
    end
    always_comb begin
        out_valid_d  = accept ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
        out_result_d = accept ? alu_result : out_result_q;
        out_wr_en_d  = accept ? (wr_req && cond_pass) : out_wr_en_q;
        flags_d      = (accept && set_flags && cond_pass) ? alu_flags : flags_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_wr_en_q  <= 1'b0;
            flags_q      <= 4'b0000;
        end else begin
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_wr_en_q  <= out_wr_en_d;
            flags_q      <= flags_d;
        end
    end
`ifdef ALU_COND_SKIP_CNT_EN
    logic [7:0] skip_cnt_q, skip_cnt_d;
    assign skip_cnt = skip_cnt_q;
    always_comb begin
        skip_cnt_d = (accept && !cond_pass && skip_cnt_q != 8'hFF) ? skip_cnt_q + 8'd1 : skip_cnt_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) skip_cnt_q <= 8'h00;
        else     skip_cnt_q <= skip_cnt_d;
    end
`endif
endmodule
